// File: rtl/calc_alu_sequencer.sv
// Sign-magnitude add/sub/mul engine behind the calculator controller.
// The operation runs on one shared adder: one pass for add/sub, or MAG_W shift-add passes for mul.
module calc_alu_sequencer #(
  parameter int MAG_W  = 15,
  parameter bit SAT_EN = 1'b1
) (
  input  logic           clk,
  input  logic           nRST,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [MAG_W:0] operand_a,
  input  logic [MAG_W:0] operand_b,
  input  logic           clear,
  output logic           busy,
  output logic           done,
  output logic [MAG_W:0] result,
  output logic           overflow,
  output logic           op_err,
  output logic [2:0]     state_dbg
);

  localparam int ACC_W = 2 * MAG_W;
  localparam int SUM_W = MAG_W + 2;
  localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDSUB = 3'd1,
    S_MUL    = 3'd2,
    S_NORM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [MAG_W:0]     a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [MAG_W:0]     result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  // Shared adder operands and normalisation terms
  logic               legal, is_mul, sb_eff;
  logic [SUM_W-1:0]   mag_a, mag_b, ta, tb;
  logic [ACC_W-1:0]   pp, add_x, add_y, add_s;
  logic               neg_n, ovf_n, sign_n;
  logic [ACC_W-1:0]   abs_n;
  logic [MAG_W-1:0]   mag_n;

  always_comb begin
    legal  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);
    is_mul = (op_q == OP_MUL);
    sb_eff = b_q[MAG_W] ^ (op_q == OP_SUB);
    mag_a  = {2'b00, a_q[MAG_W-1:0]};
    mag_b  = {2'b00, b_q[MAG_W-1:0]};
    ta     = a_q[MAG_W] ? -mag_a : mag_a;
    tb     = sb_eff ? -mag_b : mag_b;
    pp     = b_q[cnt_q] ? (ACC_W'(a_q[MAG_W-1:0]) << cnt_q) : '0;
    if (state_q == S_MUL) begin
      add_x = acc_q;
      add_y = pp;
    end else begin
      add_x = {{(ACC_W-SUM_W){ta[SUM_W-1]}}, ta};
      add_y = {{(ACC_W-SUM_W){tb[SUM_W-1]}}, tb};
    end
    add_s  = add_x + add_y;
    // add/sub keeps a signed sum in acc; mul keeps an unsigned magnitude
    neg_n  = is_mul ? (a_q[MAG_W] ^ b_q[MAG_W]) : acc_q[ACC_W-1];
    abs_n  = (!is_mul && acc_q[ACC_W-1]) ? -acc_q : acc_q;
    ovf_n  = |abs_n[ACC_W-1:MAG_W];
    mag_n  = (ovf_n && SAT_EN) ? '1 : abs_n[MAG_W-1:0];
    sign_n = neg_n && (|mag_n);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          a_d      = operand_a;
          b_d      = operand_b;
          cnt_d    = '0;
          acc_d    = '0;
          result_d = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = (op == OP_MUL) ? S_MUL : S_ADDSUB;
        end
      end
      S_ADDSUB: begin
        if (legal) acc_d = add_s;
        else       err_d = 1'b1;
        state_d = S_NORM;
      end
      S_MUL: begin
        acc_d = add_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MAG_W - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (legal) begin
          result_d = {sign_n, mag_n};
          ovf_d    = ovf_n;
        end else begin
          result_d = '0;
          ovf_d    = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle start; visible outputs stay frozen.
    if (clear) begin
      state_d  = S_IDLE;
      result_d = result_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign op_err    = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Bench for calc_alu_sequencer: directed vector table, random ops against an integer model,
// and hand sequences for start-while-busy, clear, and reset mid-multiply.
module tb_calc_alu_sequencer;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [15:0] operand_a = '0;
  logic [15:0] operand_b = '0;
  logic        clear = 1'b0;
  logic        busy, done, overflow, op_err;
  logic [15:0] result;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b011;
  localparam logic [2:0] MUL = 3'b100;

  calc_alu_sequencer #(.MAG_W(15), .SAT_EN(1'b1)) dut (
    .clk(clk), .nRST(nRST), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .clear(clear),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .op_err(op_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: signed integer arithmetic, then clamp to the sign-magnitude output range.
  function automatic logic [17:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    int va, vb, t, m;
    logic ov;
    va = a[15] ? -int'(a[14:0]) : int'(a[14:0]);
    vb = b[15] ? -int'(b[14:0]) : int'(b[14:0]);
    case (o)
      ADD:     t = va + vb;
      SUB:     t = va - vb;
      MUL:     t = va * vb;
      default: return {1'b1, 1'b0, 16'h0000};
    endcase
    m  = (t < 0) ? -t : t;
    ov = (m > 32767);
    if (ov) m = 32767;
    return {1'b0, ov, ((t < 0) && (m != 0)), m[14:0]};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [17:0] exp, input int inject_at);
    int lat, busy_n;
    bit seen;
    lat = 0; busy_n = 0; seen = 0;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); operand_a = 16'($urandom); operand_b = 16'($urandom);
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (k == 1) chk({tag, " capture clears"}, {15'd0, result, overflow, op_err}, 32'd0);
      if (k == inject_at) begin
        start = 1'b1; op = ADD; operand_a = 16'h0001; operand_b = 16'h0001;
      end else if (k == inject_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        lat = k;
      end
    end
    if (!seen) begin
      chk({tag, " done timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " result"}, {16'd0, result}, {16'd0, exp[15:0]});
      chk({tag, " flags"}, {30'd0, overflow, op_err}, {30'd0, exp[16], exp[17]});
      chk({tag, " latency"}, lat, (o == MUL) ? 17 : 3);
      chk({tag, " busy cycles"}, busy_n, (o == MUL) ? 17 : 3);
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, " back to idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    logic [2:0] ro;
    logic [15:0] ra, rb;

    vecs[0]  = '{ADD,    16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0};
    vecs[1]  = '{ADD,    16'h8019, 16'h800F, 16'h8028, 1'b0, 1'b0};
    vecs[2]  = '{SUB,    16'h0003, 16'h0005, 16'h8002, 1'b0, 1'b0};
    vecs[3]  = '{SUB,    16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{MUL,    16'h00B5, 16'h00B5, 16'h7FF9, 1'b0, 1'b0};
    vecs[5]  = '{MUL,    16'h9249, 16'h0007, 16'hFFFF, 1'b0, 1'b0};
    vecs[6]  = '{MUL,    16'h0000, 16'h8001, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{ADD,    16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    vecs[8]  = '{MUL,    16'h00C8, 16'h00C8, 16'h7FFF, 1'b1, 1'b0};
    vecs[9]  = '{3'b111, 16'h0012, 16'h0034, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{ADD,    16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{ADD,    16'h8005, 16'h0003, 16'h8002, 1'b0, 1'b0};
    vecs[12] = '{ADD,    16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    vecs[13] = '{MUL,    16'h80C8, 16'h00C8, 16'hFFFF, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("reset outputs", {12'd0, result, busy, done, overflow, op_err}, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             {vecs[i].err, vecs[i].ovf, vecs[i].res}, 0);

    // Start pulsed during a multiply is ignored
    run_op("start in mul", MUL, 16'h00B5, 16'h00B5, {2'b00, 16'h7FF9}, 5);
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    chk("start in mul dropped", n_done, 0);

    // Clear at multiply step 5
    run_op("pre clear", ADD, 16'h0002, 16'h0003, {2'b00, 16'h0005}, 0);
    start = 1'b1; op = MUL; operand_a = 16'h0011; operand_b = 16'h0013;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    chk("clear busy before", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("clear idle", {31'd0, busy}, 32'd0);
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("clear no done", n_done, 0);
    chk("clear result held", {14'd0, result, overflow, op_err}, 32'd0);

    // Clear and start together: start dropped, previous result kept
    run_op("pre clear start", ADD, 16'h0004, 16'h0003, {2'b00, 16'h0007}, 0);
    start = 1'b1; clear = 1'b1; op = ADD; operand_a = 16'h0001; operand_b = 16'h0001;
    @(posedge clk);
    #1 start = 1'b0; clear = 1'b0;
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy || done) n_done++;
    end
    chk("clear+start dropped", n_done, 0);
    chk("clear+start result", {16'd0, result}, 32'h0007);

    // Reset in idle clears held outputs at once
    run_op("pre reset", ADD, 16'h7FFF, 16'h0001, {2'b01, 16'h7FFF}, 0);
    nRST = 1'b0;
    #1;
    chk("reset idle outputs", {12'd0, result, busy, done, overflow, op_err}, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);

    // Reset mid-multiply, then a normal add
    start = 1'b1; op = MUL; operand_a = 16'h00C8; operand_b = 16'h00C8;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("mul busy before reset", {31'd0, busy}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("reset mid mul", {12'd0, result, busy, done, overflow, op_err}, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    run_op("after reset", ADD, 16'h0002, 16'h0003, {2'b00, 16'h0005}, 0);

    // Random operations against the model
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: ro = ADD;
        1: ro = SUB;
        2: ro = MUL;
        default: begin
          ro = 3'($urandom_range(0, 7));
          if (ro == ADD || ro == SUB || ro == MUL) ro = 3'b111;
        end
      endcase
      if (ro == MUL && $urandom_range(0, 1) == 1) begin
        ra = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 300))};
        rb = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 300))};
      end else begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end
      run_op($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, model(ro, ra, rb), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
